// File: rtl/cla_mp_pkg.sv
// ============================================================================
// Module : cla_mp_pkg
// Brief  : Shared types and constants for the multi-precision CLA controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cla_mp_pkg;

  localparam int WORD_W        = 32;
  localparam int DEF_MAX_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage : cla_mp_pkg

`default_nettype wire

// File: rtl/cla_mp_add_ctrl_cla.sv
// ============================================================================
// Module : CLA_adder
// Brief  : 32-bit two-level carry-lookahead adder. Eight 4-bit groups each
//          compute their internal carries from the group carry-in; group
//          generate/propagate terms are combined into the group carries.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module CLA_adder (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] Sum,
  output logic        Cout,
  output logic        Overflow
);

  logic [31:0] g;
  logic [31:0] p;
  logic [7:0]  grp_g;
  logic [7:0]  grp_p;
  logic [8:0]  gc;
  logic [31:0] bit_cin;

  assign g = A & B;
  assign p = A ^ B;

  // Per-group generate/propagate and in-group lookahead carries
  for (genvar k = 0; k < 8; k++) begin : g_grp
    localparam int BB = 4 * k;

    assign grp_g[k] = g[BB+3]
                    | (p[BB+3] & g[BB+2])
                    | (p[BB+3] & p[BB+2] & g[BB+1])
                    | (p[BB+3] & p[BB+2] & p[BB+1] & g[BB]);
    assign grp_p[k] = p[BB+3] & p[BB+2] & p[BB+1] & p[BB];

    assign bit_cin[BB]   = gc[k];
    assign bit_cin[BB+1] = g[BB] | (p[BB] & gc[k]);
    assign bit_cin[BB+2] = g[BB+1] | (p[BB+1] & g[BB])
                         | (p[BB+1] & p[BB] & gc[k]);
    assign bit_cin[BB+3] = g[BB+2] | (p[BB+2] & g[BB+1])
                         | (p[BB+2] & p[BB+1] & g[BB])
                         | (p[BB+2] & p[BB+1] & p[BB] & gc[k]);
  end

  // Group-level carry chain from the group G/P terms
  always_comb begin
    gc[0] = Cin;
    for (int k = 0; k < 8; k++) begin
      gc[k+1] = grp_g[k] | (grp_p[k] & gc[k]);
    end
  end

  assign Sum      = p ^ bit_cin;
  assign Cout     = gc[8];
  assign Overflow = gc[8] ^ bit_cin[31];

endmodule : CLA_adder

`default_nettype wire

// File: rtl/cla_mp_add_ctrl.sv
// ============================================================================
// Module : cla_mp_add_ctrl
// Brief  : Multi-precision add/subtract controller. Streams 32-bit operand
//          words LS-first through one shared CLA, chaining the carry between
//          words, and streams sum words out over valid/ready.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_mp_add_ctrl
  import cla_mp_pkg::*;
#(
  parameter int MAX_WORDS = DEF_MAX_WORDS,
  parameter int CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sub,
  input  logic [CW-1:0]     nwords,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] A_word,
  input  logic [WORD_W-1:0] B_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] Sum_word,
  output logic              out_last,
  output logic              Cout,
  output logic              Overflow,
  output logic              done
);

  state_t            state;
  logic              sub_q;
  logic [CW-1:0]     len_q;
  logic              carry_q;
  logic [CW-1:0]     word_cnt;

  logic [WORD_W-1:0] cla_b;
  logic [WORD_W-1:0] cla_sum;
  logic              cla_cout;
  logic              cla_ovf;
  logic              accept;
  logic              last_word;
  logic              legal_len;

  // Subtraction is A + ~B + 1; the +1 comes from carry_q being preset to sub
  assign cla_b = sub_q ? ~B_word : B_word;

  CLA_adder u_cla (
    .A        (A_word),
    .B        (cla_b),
    .Cin      (carry_q),
    .Sum      (cla_sum),
    .Cout     (cla_cout),
    .Overflow (cla_ovf)
  );

  assign busy      = (state != IDLE);
  assign in_ready  = (state == RUN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign last_word = (word_cnt == len_q - CW'(1));
  assign legal_len = (nwords != '0) && (nwords <= CW'(MAX_WORDS));

  // Controller FSM, carry chain, counter and final flag capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sub_q    <= 1'b0;
      len_q    <= '0;
      carry_q  <= 1'b0;
      word_cnt <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && legal_len) begin
            sub_q    <= sub;
            len_q    <= nwords;
            carry_q  <= sub;
            word_cnt <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            carry_q  <= cla_cout;
            word_cnt <= word_cnt + CW'(1);
            if (last_word) begin
              Cout     <= cla_cout;
              Overflow <= cla_ovf;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_valid && out_ready && out_last) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // One-deep output register: load on accept, empty when consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      Sum_word  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_last  <= last_word;
      Sum_word  <= cla_sum;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule : cla_mp_add_ctrl

`default_nettype wire

// File: tb/tb_cla_mp_add_ctrl.sv
// ============================================================================
// Module : tb_cla_mp_add_ctrl
// Brief  : Directed self-checking bench for cla_mp_add_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla_mp_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [3:0]  nwords;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A_word;
  logic [31:0] B_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Sum_word;
  logic        out_last;
  logic        Cout;
  logic        Overflow;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] a_v [8];
  logic [31:0] b_v [8];
  logic [31:0] got_sum [8];
  logic        got_last [8];
  int          got_n;
  logic        done1, done2, busy2, cout_g, ovf_g;

  cla_mp_add_ctrl #(.MAX_WORDS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .nwords(nwords),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .A_word(A_word), .B_word(B_word), .out_valid(out_valid),
    .out_ready(out_ready), .Sum_word(Sum_word), .out_last(out_last),
    .Cout(Cout), .Overflow(Overflow), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // Streams nwords=n operands from a_v/b_v with out_ready held high and
  // records every result word plus the done/flag state afterwards.
  task automatic do_op(input int n, input logic s, input bit poke);
    int idx;
    bit acc;
    int guard;
    idx = 0; acc = 0; guard = 0; got_n = 0;
    for (int i = 0; i < 8; i++) begin
      got_sum[i]  = 32'hDEADBEEF;
      got_last[i] = 1'bx;
    end
    @(negedge clk); start = 1; sub = s; nwords = 4'(n);
    while (got_n < n && guard < 40) begin
      @(negedge clk);
      start = 0;
      if (acc) idx++;
      if (poke && idx == 1) begin start = 1; sub = ~s; nwords = 4'd1; end
      if (idx < n) begin
        in_valid = 1; A_word = a_v[idx]; B_word = b_v[idx];
      end else begin
        in_valid = 0;
      end
      out_ready = 1;
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
        got_sum[got_n]  = Sum_word;
        got_last[got_n] = out_last;
        got_n++;
      end
      guard++;
    end
    in_valid = 0;
    start    = 0;
    @(negedge clk); #1; done1 = done; cout_g = Cout; ovf_g = Overflow;
    @(negedge clk); #1; done2 = done; busy2 = busy;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; sub = 0; nwords = 0; in_valid = 0; out_ready = 0;
    A_word = 0; B_word = 0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({busy, in_ready, out_valid, out_last, Sum_word, Cout, Overflow, done} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {busy, in_ready, out_valid, out_last, Sum_word, Cout, Overflow, done});
    end
    @(negedge clk); rst = 0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_add64();
    a_v[0] = 32'hFFFFFFFF; b_v[0] = 32'h1;
    a_v[1] = 32'hFFFFFFFF; b_v[1] = 32'h0;
    do_op(2, 1'b0, 1'b0);
    n_checks++;
    if (got_n !== 2) begin n_fail++; $display("FAIL add64_count: got %0d expected 2", got_n); end
    n_checks++;
    if (got_sum[0] !== 32'h0) begin n_fail++; $display("FAIL add64_w0: got %h expected 00000000", got_sum[0]); end
    n_checks++;
    if (got_sum[1] !== 32'h0) begin n_fail++; $display("FAIL add64_w1: got %h expected 00000000", got_sum[1]); end
    n_checks++;
    if ({got_last[0], got_last[1]} !== 2'b01) begin
      n_fail++; $display("FAIL add64_last: got %b%b expected 01", got_last[0], got_last[1]);
    end
    n_checks++;
    if ({cout_g, ovf_g} !== 2'b10) begin
      n_fail++; $display("FAIL add64_flags: got cout=%b ovf=%b expected cout=1 ovf=0", cout_g, ovf_g);
    end
    n_checks++;
    if ({done1, done2, busy2} !== 3'b100) begin
      n_fail++; $display("FAIL add64_done_pulse: got %b%b%b expected 100", done1, done2, busy2);
    end
  endtask

  task automatic test_sub_overflow();
    a_v[0] = 32'h80000000; b_v[0] = 32'h00000001;
    do_op(1, 1'b1, 1'b0);
    n_checks++;
    if (got_sum[0] !== 32'h7FFFFFFF) begin
      n_fail++; $display("FAIL sub32_sum: got %h expected 7fffffff", got_sum[0]);
    end
    n_checks++;
    if ({cout_g, ovf_g, got_last[0], done1} !== 4'b1111) begin
      n_fail++; $display("FAIL sub32_flags: got cout=%b ovf=%b last=%b done=%b expected 1111",
                         cout_g, ovf_g, got_last[0], done1);
    end
  endtask

  task automatic test_sub96_borrow();
    for (int i = 0; i < 3; i++) a_v[i] = 32'h0;
    b_v[0] = 32'h1; b_v[1] = 32'h0; b_v[2] = 32'h0;
    do_op(3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_sum[i] !== 32'hFFFFFFFF) begin
        n_fail++; $display("FAIL sub96_w%0d: got %h expected ffffffff", i, got_sum[i]);
      end
    end
    n_checks++;
    if ({cout_g, ovf_g, done1} !== 3'b001) begin
      n_fail++; $display("FAIL sub96_flags: got cout=%b ovf=%b done=%b expected 0 0 1", cout_g, ovf_g, done1);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_s [4];
    exp_s = '{32'h00000001, 32'd12, 32'h80000000, 32'h80000000};
    a_v[0] = 32'hFFFFFFFF; b_v[0] = 32'h2;
    a_v[1] = 32'h5;        b_v[1] = 32'h6;
    a_v[2] = 32'h7FFFFFFF; b_v[2] = 32'h1;
    a_v[3] = 32'h7FFFFFFF; b_v[3] = 32'h1;
    @(negedge clk); start = 1; sub = 0; nwords = 4'd4;
    @(negedge clk); start = 0; in_valid = 1; A_word = a_v[0]; B_word = b_v[0]; out_ready = 0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready: got %b expected 1", in_ready); end
    @(negedge clk); A_word = a_v[1]; B_word = b_v[1];
    for (int h = 0; h < 3; h++) begin
      #1;
      n_checks++;
      if ({out_valid, in_ready, Sum_word} !== {1'b1, 1'b0, exp_s[0]}) begin
        n_fail++; $display("FAIL bp_hold%0d: got valid=%b ready=%b sum=%h expected 1 0 %h",
                           h, out_valid, in_ready, Sum_word, exp_s[0]);
      end
      @(negedge clk);
    end
    out_ready = 1;
    #1;
    n_checks++;
    if ({in_ready, Sum_word} !== {1'b1, exp_s[0]}) begin
      n_fail++; $display("FAIL bp_release: got ready=%b sum=%h expected 1 %h", in_ready, Sum_word, exp_s[0]);
    end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      if (k < 3) begin A_word = a_v[k+1]; B_word = b_v[k+1]; end
      else in_valid = 0;
      #1;
      n_checks++;
      if ({out_valid, out_last, Sum_word} !== {1'b1, (k == 3), exp_s[k]}) begin
        n_fail++; $display("FAIL bp_stream%0d: got valid=%b last=%b sum=%h expected 1 %b %h",
                           k, out_valid, out_last, Sum_word, (k == 3), exp_s[k]);
      end
      if (k < 3) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_rate%0d: got ready=%b expected 1", k, in_ready); end
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if ({done, Cout, Overflow} !== 3'b101) begin
      n_fail++; $display("FAIL bp_done_flags: got done=%b cout=%b ovf=%b expected 1 0 1", done, Cout, Overflow);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({done, busy, Cout, Overflow} !== 4'b0001) begin
      n_fail++; $display("FAIL bp_after_done: got done=%b busy=%b cout=%b ovf=%b expected 0 0 0 1",
                         done, busy, Cout, Overflow);
    end
  endtask

  task automatic test_illegal_start();
    logic [3:0] bad [2];
    logic       seen;
    bad = '{4'd0, 4'd9};
    for (int t = 0; t < 2; t++) begin
      @(negedge clk); start = 1; sub = 0; nwords = bad[t];
      @(negedge clk); start = 0;
      seen = 0;
      for (int c = 0; c < 3; c++) begin
        #1; seen = seen | busy | done | in_ready;
        @(negedge clk);
      end
      n_checks++;
      if (seen !== 1'b0) begin
        n_fail++; $display("FAIL illegal_start_n%0d: got activity=%b expected 0", bad[t], seen);
      end
    end
    // start during RUN must not change the captured length or operation
    a_v[0] = 32'h1; b_v[0] = 32'h1;
    a_v[1] = 32'h2; b_v[1] = 32'h1;
    a_v[2] = 32'h3; b_v[2] = 32'h1;
    do_op(3, 1'b0, 1'b1);
    n_checks++;
    if ({got_sum[0], got_sum[1], got_sum[2]} !== {32'd2, 32'd3, 32'd4}) begin
      n_fail++; $display("FAIL run_start_ignored: got %h %h %h expected 2 3 4",
                         got_sum[0], got_sum[1], got_sum[2]);
    end
    n_checks++;
    if ({got_last[1], got_last[2], done1} !== 3'b011) begin
      n_fail++; $display("FAIL run_start_len: got last1=%b last2=%b done=%b expected 0 1 1",
                         got_last[1], got_last[2], done1);
    end
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    @(negedge clk); start = 1; sub = 0; nwords = 4'd4;
    @(negedge clk); start = 0; in_valid = 1; out_ready = 1;
    A_word = 32'hFFFFFFFF; B_word = 32'h1;
    @(negedge clk); A_word = 32'hFFFFFFFF; B_word = 32'h0;
    @(negedge clk); rst = 1; in_valid = 0;
    @(negedge clk); #1;
    n_checks++;
    if ({busy, in_ready, out_valid, out_last, Sum_word, Cout, Overflow, done} !== 39'd0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h expected 0",
                         {busy, in_ready, out_valid, out_last, Sum_word, Cout, Overflow, done});
    end
    rst = 0;
    seen_done = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1; seen_done = seen_done | done | busy;
    end
    n_checks++;
    if (seen_done !== 1'b0) begin n_fail++; $display("FAIL midreset_no_done: got %b expected 0", seen_done); end
    a_v[0] = 32'd5; b_v[0] = 32'd7;
    do_op(1, 1'b0, 1'b0);
    n_checks++;
    if ({got_sum[0], cout_g, ovf_g, done1} !== {32'd12, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL midreset_fresh_add: got sum=%h cout=%b ovf=%b done=%b expected 0000000c 0 0 1",
                         got_sum[0], cout_g, ovf_g, done1);
    end
  endtask

  initial begin
    test_reset();
    test_add64();
    test_sub_overflow();
    test_sub96_borrow();
    test_backpressure();
    test_illegal_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cla_mp_add_ctrl

`default_nettype wire

// File: doc/cla_mp_add_ctrl.md
Name: cla_mp_add_ctrl

Overview:
- Multi-precision add/subtract controller built around one shared 32-bit carry-lookahead adder instance, `CLA_adder`.
- It adds operands of 1 to MAX_WORDS 32-bit words. Words stream in least-significant first.
- The carry from each word is registered and fed into the next word's Cin.
- Sum words stream out over a valid/ready interface. The final word's Cout and signed Overflow are reported with a one-cycle done pulse.

Parameters:
- MAX_WORDS, 8, maximum operand length in 32-bit words.
- CW, $clog2(MAX_WORDS+1), width of the word-count field.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin an operation; sampled only in IDLE.
- sub  in  1  0 = A+B, 1 = A-B; captured at start.
- nwords  in  CW  operand length in words; captured at start.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  A_word/B_word valid.
- in_ready  out  1  controller accepts a word this cycle.
- A_word  in  32  operand A word.
- B_word  in  32  operand B word.
- out_valid  out  1  Sum_word valid.
- out_ready  in  1  downstream accepts Sum_word.
- Sum_word  out  32  result word.
- out_last  out  1  marks the final result word.
- Cout  out  1  final carry-out; for subtract, 1 = no borrow.
- Overflow  out  1  final signed overflow.
- done  out  1  one-cycle pulse; Cout and Overflow valid and held until the next start.

Behaviour:
- Reset (synchronous, rst=1): state=IDLE, carry_q=0, word counter=0. All outputs read 0: busy, in_ready, out_valid, out_last, Sum_word, Cout, Overflow, done.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN when start=1 and 1<=nwords<=MAX_WORDS. Captures sub_q and len_q, sets carry_q=sub, clears the counter, clears Cout and Overflow.
  - Illegal start (nwords=0 or nwords>MAX_WORDS) is ignored; the controller stays in IDLE.
  - start outside IDLE is ignored.
- Datapath, driven combinationally:
  - CLA A = A_word.
  - CLA B = sub_q ? ~B_word : B_word.
  - CLA Cin = carry_q.
- in_ready = (state==RUN) && (!out_valid || out_ready). Output-register skid is one deep; there is no internal FIFO.
- Word accepted (in_valid && in_ready):
  - Sum_word <= CLA Sum; out_valid <= 1.
  - carry_q <= CLA Cout; counter increments.
  - out_last <= 1 when this is word len_q-1.
  - On the last word, also capture Cout and Overflow from the CLA and go to DRAIN.
- Latency: a result word appears on Sum_word the cycle after its input is accepted. Full throughput is one word per cycle when out_ready stays high.
- Output handshake: out_valid falls when out_ready=1 and no new word is accepted that cycle. Sum_word and out_last stay stable while out_valid=1 && out_ready=0.
- DRAIN -> DONE when the last word is consumed (out_valid && out_ready && out_last).
- DONE: done=1 for exactly one cycle, then IDLE. Cout and Overflow hold their values until the next legal start.
- Simultaneous events: downstream consuming word k in the same cycle word k+1 is accepted is legal; out_valid stays 1 with the new data.
- rst in any state aborts the operation: the partial result is discarded and no done pulse is produced.
- Width rules:
  - All 32-bit arithmetic is done by the CLA only; no other adder is inferred.
  - The counter is CW bits wide and never wraps, because len_q<=MAX_WORDS.

Decomposition:
- Package cla_mp_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - WORD_W=32;
  - the default MAX_WORDS constant.
- Sub-module: the existing `CLA_adder`, instantiated once, with no modification.
- The controller FSM and the output register stay in cla_mp_add_ctrl; a further split is not warranted.

Test Plan:
- 64-bit add: nwords=2, sub=0, A={0xFFFFFFFF,0xFFFFFFFF}, B={0,1}, words LS first.
  -> Sum words 0x00000000, 0x00000000; out_last on word 2; Cout=1, Overflow=0; done pulse 1 cycle after the last handshake.
- 32-bit subtract overflow: nwords=1, sub=1, A=0x80000000, B=0x00000001.
  -> Sum=0x7FFFFFFF, Cout=1, Overflow=1.
- 96-bit subtract with borrow chain: A={0,0,0}, B={0,0,1}.
  -> Sum words 0xFFFFFFFF ×3, Cout=0, Overflow=0.
- Backpressure: nwords=4, out_ready held 0 for 3 cycles after the first result.
  -> in_ready=0 while the output is held; Sum_word is stable; all 4 words are correct once out_ready=1.
  -> Then out_ready=1 continuously: one word per cycle.
- Illegal and redundant start:
  - nwords=0 -> busy stays 0, no done.
  - nwords=MAX_WORDS+1 -> busy stays 0, no done.
  - start pulsed during RUN -> no effect on len_q or sub_q.
- Reset mid-operation: rst after word 2 of 4.
  -> Next cycle all outputs are 0 and state is IDLE.
  -> A new 1-word add 5+7 gives Sum=12, Cout=0, with no stale carry.
